mc_ctrl_fsm: RTL and testbench
==============================

// Module: mc_ctrl_fsm
// PURPOSE
//  Multicycle control FSM for the RISC-V core. Sequences FETCH/DECODE/EXEC/MEM/WB per instruction.
//  Drives PC/IR/register-file/memory strobes, ALU operand and op selects, and the 2-bit write-back
//  select consumed by mux3_32 (WDSEL_ALU=00, WDSEL_DM=01, WDSEL_JMP=10). Sits beside the datapath
//  and is the only source of its control signals.
// PARAMETERS
//  TIMEOUT  255  max consecutive cycles waiting on mem_ready before bus_err; must be >=1, <=2^CNT_W-1
//  CNT_W    8    width of the wait counter
// PORTS
//  clk           in   1  rising-edge clock
//  rst           in   1  synchronous, active-high reset
//  instr_op      in   7  opcode field of IR (valid from DECODE onward)
//  mem_ready     in   1  memory handshake: access completes in the cycle it is 1
//  branch_taken  in   1  branch comparator result, sampled in EXEC
//  pc_write      out  1  PC load strobe
//  pc_src        out  2  00 pc+4, 01 pc+imm (branch/JAL), 10 ALU result (JALR)
//  ir_write      out  1  IR load strobe
//  mem_read      out  1  memory read request (instr in FETCH, data in MEM)
//  mem_write     out  1  memory write request
//  reg_write     out  1  register-file write strobe
//  wd_sel        out  2  write-back select to mux3_32: 00 ALU, 01 DM, 10 JMP (pc+4)
//  alu_src_b     out  1  0 rs2, 1 immediate
//  alu_op        out  2  00 add, 01 sub/compare, 10 funct-decoded, 11 pass-B (LUI)
//  illegal       out  1  one-cycle pulse: unsupported opcode in DECODE
//  bus_err       out  1  one-cycle pulse: mem_ready wait reached TIMEOUT
//  state         out  3  current state: FETCH=0 DECODE=1 EXEC=2 MEM=3 WB=4
// BEHAVIOUR
//  - Reset: state<=FETCH, op_q<=0, wait_cnt<=0. While rst=1 all strobe outputs are forced to 0.
//    rst overrides any state, including mid-MEM; no write strobe is issued in the reset cycle.
//  - State, op_q and wait_cnt are registered. All other outputs are combinational from
//    state, op_q, mem_ready and branch_taken.
//  - Unlisted outputs are 0 in every state. wd_sel=00 unless stated otherwise.
//  - FETCH: mem_read=1. If mem_ready=1: ir_write=1, pc_write=1, pc_src=00, next DECODE.
//    Otherwise hold and increment wait_cnt.
//  - DECODE: op_q<=instr_op. Supported opcodes:
//    R 0110011, I-ALU 0010011, LW 0000011, SW 0100011, BR 1100011, JAL 1101111, JALR 1100111, LUI 0110111.
//    Supported -> EXEC. Unsupported -> illegal=1, next FETCH, no other strobe.
//  - EXEC:
//    R: alu_op=10, alu_src_b=0 -> WB.
//    I-ALU: alu_op=10, alu_src_b=1 -> WB.
//    LUI: alu_op=11, alu_src_b=1 -> WB.
//    LW/SW: alu_op=00, alu_src_b=1 -> MEM.
//    BR: alu_op=01, alu_src_b=0; pc_write=branch_taken, pc_src=01 -> FETCH.
//    JAL/JALR: alu_op=00, alu_src_b=1 -> WB.
//  - MEM: LW asserts mem_read; SW asserts mem_write. Hold until mem_ready=1.
//    On mem_ready: LW -> WB, SW -> FETCH.
//  - WB: reg_write=1, then -> FETCH.
//    R/I-ALU/LUI: wd_sel=00. LW: wd_sel=01.
//    JAL: wd_sel=10, pc_write=1, pc_src=01. JALR: wd_sel=10, pc_write=1, pc_src=10.
//  - Wait counter: cleared on any state change and on mem_ready=1; increments only in FETCH/MEM
//    while mem_ready=0. When wait_cnt==TIMEOUT-1 and mem_ready=0: bus_err=1 for that cycle,
//    next FETCH, wait_cnt<=0. No write strobe is issued for the abandoned access.
//  - mem_ready=1 outside FETCH/MEM is ignored.
//  - Latency with zero-wait memory: R/I/LUI/JAL/JALR 4 cycles; LW 5; SW 4; BR 3.
// TESTING
//  1) R-type (0110011), mem_ready=1 always -> state 0,1,2,4,0.
//     reg_write=1 only in WB with wd_sel=00; ir_write and pc_write only in FETCH.
//  2) LW, mem_ready low 3 cycles in MEM -> MEM held 4 cycles with mem_read=1, then WB with wd_sel=01, reg_write=1.
//  3) BR with branch_taken=1 -> EXEC pc_write=1, pc_src=01.
//     Repeat with branch_taken=0 -> pc_write=0 in EXEC. Both return to FETCH after 3 cycles.
//  4) JAL -> WB: reg_write=1, wd_sel=10, pc_write=1, pc_src=01. JALR -> same with pc_src=10.
//  5) instr_op=7'h7F -> illegal pulse in DECODE, next FETCH, no reg_write or mem_write.
//     TIMEOUT=4 with mem_ready=0 in FETCH -> bus_err on 4th cycle, then FETCH with wait_cnt=0.
//  6) SW, assert rst in MEM with mem_ready=1 -> mem_write=0 that cycle, next state FETCH, op_q=0.

Source files
------------

// File: rtl/mc_ctrl_fsm.sv
`default_nettype none
// ============================================================================
// Module   : mc_ctrl_fsm
// Purpose  : Multicycle control FSM for the RISC-V core. Walks each
//            instruction through FETCH/DECODE/EXEC/MEM/WB and generates every
//            datapath control signal (PC/IR/RF/memory strobes, ALU selects,
//            write-back select for mux3_32).
// Ports    : clk, rst          - clock, synchronous active-high reset
//            instr_op_i[6:0]   - IR opcode field (valid from DECODE onward)
//            mem_ready_i       - memory access completes in the cycle it is 1
//            branch_taken_i    - branch comparator result, used in EXEC
//            pc_write_o, pc_src_o[1:0], ir_write_o, mem_read_o, mem_write_o,
//            reg_write_o, wd_sel_o[1:0], alu_src_b_o, alu_op_o[1:0]
//                              - datapath controls
//            illegal_o, bus_err_o - one-cycle error pulses
//            state_o[2:0]      - current state (FETCH=0 .. WB=4)
// Revision : 1.0 - initial release
// ============================================================================
module mc_ctrl_fsm #(
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] instr_op_i,
    input  logic       mem_ready_i,
    input  logic       branch_taken_i,
    output logic       pc_write_o,
    output logic [1:0] pc_src_o,
    output logic       ir_write_o,
    output logic       mem_read_o,
    output logic       mem_write_o,
    output logic       reg_write_o,
    output logic [1:0] wd_sel_o,
    output logic       alu_src_b_o,
    output logic [1:0] alu_op_o,
    output logic       illegal_o,
    output logic       bus_err_o,
    output logic [2:0] state_o
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4
    } state_t;

    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_BR   = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_JALR = 7'b1100111;
    localparam logic [6:0] OP_LUI  = 7'b0110111;

    localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(TIMEOUT - 1);

    state_t           state_q, state_d;
    logic [6:0]       op_q, op_d;
    logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic             w_timeout;

    function automatic logic op_supported(input logic [6:0] op);
        case (op)
            OP_R, OP_I, OP_LW, OP_SW, OP_BR, OP_JAL, OP_JALR, OP_LUI: op_supported = 1'b1;
            default:                                                  op_supported = 1'b0;
        endcase
    endfunction

    // Last permitted wait cycle with memory still not ready.
    assign w_timeout = (wait_cnt_q == WAIT_LAST) && !mem_ready_i;
    assign state_o   = state_q;

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        wait_cnt_d  = '0;          // cleared unless a wait cycle extends it
        pc_write_o  = 1'b0;
        pc_src_o    = 2'b00;
        ir_write_o  = 1'b0;
        mem_read_o  = 1'b0;
        mem_write_o = 1'b0;
        reg_write_o = 1'b0;
        wd_sel_o    = 2'b00;
        alu_src_b_o = 1'b0;
        alu_op_o    = 2'b00;
        illegal_o   = 1'b0;
        bus_err_o   = 1'b0;

        case (state_q)
            S_FETCH: begin
                mem_read_o = 1'b1;
                if (mem_ready_i) begin
                    ir_write_o = 1'b1;
                    pc_write_o = 1'b1;
                    state_d    = S_DECODE;
                end else if (w_timeout) begin
                    bus_err_o = 1'b1;
                    state_d   = S_FETCH;
                end else begin
                    wait_cnt_d = wait_cnt_q + CNT_W'(1);
                end
            end
            S_DECODE: begin
                op_d = instr_op_i;
                if (op_supported(instr_op_i)) begin
                    state_d = S_EXEC;
                end else begin
                    illegal_o = 1'b1;
                    state_d   = S_FETCH;
                end
            end
            S_EXEC: begin
                case (op_q)
                    OP_R: begin
                        alu_op_o = 2'b10;
                        state_d  = S_WB;
                    end
                    OP_I: begin
                        alu_op_o    = 2'b10;
                        alu_src_b_o = 1'b1;
                        state_d     = S_WB;
                    end
                    OP_LUI: begin
                        alu_op_o    = 2'b11;
                        alu_src_b_o = 1'b1;
                        state_d     = S_WB;
                    end
                    OP_LW, OP_SW: begin
                        alu_src_b_o = 1'b1;
                        state_d     = S_MEM;
                    end
                    OP_BR: begin
                        alu_op_o   = 2'b01;
                        pc_write_o = branch_taken_i;
                        pc_src_o   = 2'b01;
                        state_d    = S_FETCH;
                    end
                    OP_JAL, OP_JALR: begin
                        alu_src_b_o = 1'b1;
                        state_d     = S_WB;
                    end
                    default: state_d = S_FETCH;
                endcase
            end
            S_MEM: begin
                if (op_q == OP_LW) mem_read_o  = 1'b1;
                else               mem_write_o = 1'b1;
                if (mem_ready_i) begin
                    state_d = (op_q == OP_LW) ? S_WB : S_FETCH;
                end else if (w_timeout) begin
                    // Abandoned access: drop the write request on the give-up cycle.
                    bus_err_o   = 1'b1;
                    mem_write_o = 1'b0;
                    state_d     = S_FETCH;
                end else begin
                    wait_cnt_d = wait_cnt_q + CNT_W'(1);
                end
            end
            S_WB: begin
                reg_write_o = 1'b1;
                state_d     = S_FETCH;
                case (op_q)
                    OP_LW:   wd_sel_o = 2'b01;
                    OP_JAL: begin
                        wd_sel_o   = 2'b10;
                        pc_write_o = 1'b1;
                        pc_src_o   = 2'b01;
                    end
                    OP_JALR: begin
                        wd_sel_o   = 2'b10;
                        pc_write_o = 1'b1;
                        pc_src_o   = 2'b10;
                    end
                    default: wd_sel_o = 2'b00;
                endcase
            end
            default: state_d = S_FETCH;
        endcase

        // Reset wins over whatever the current state would request.
        if (rst) begin
            pc_write_o  = 1'b0;
            pc_src_o    = 2'b00;
            ir_write_o  = 1'b0;
            mem_read_o  = 1'b0;
            mem_write_o = 1'b0;
            reg_write_o = 1'b0;
            wd_sel_o    = 2'b00;
            alu_src_b_o = 1'b0;
            alu_op_o    = 2'b00;
            illegal_o   = 1'b0;
            bus_err_o   = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_FETCH;
            op_q       <= '0;
            wait_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mc_ctrl_fsm.sv
`default_nettype none
// ============================================================================
// Module   : tb_mc_ctrl_fsm
// Purpose  : Directed self-checking bench for mc_ctrl_fsm. Each cycle the
//            full control word is compared against a hand-written expected
//            word (TIMEOUT fixed at 4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_mc_ctrl_fsm;

    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_BR   = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_JALR = 7'b1100111;
    localparam logic [6:0] OP_LUI  = 7'b0110111;

    logic       clk = 1'b0;
    logic       rst;
    logic [6:0] instr_op;
    logic       mem_ready;
    logic       branch_taken;
    logic       pc_write, ir_write, mem_read, mem_write, reg_write;
    logic       alu_src_b, illegal, bus_err;
    logic [1:0] pc_src, wd_sel, alu_op;
    logic [2:0] state;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    mc_ctrl_fsm #(.TIMEOUT(4), .CNT_W(8)) dut (
        .clk            (clk),
        .rst            (rst),
        .instr_op_i     (instr_op),
        .mem_ready_i    (mem_ready),
        .branch_taken_i (branch_taken),
        .pc_write_o     (pc_write),
        .pc_src_o       (pc_src),
        .ir_write_o     (ir_write),
        .mem_read_o     (mem_read),
        .mem_write_o    (mem_write),
        .reg_write_o    (reg_write),
        .wd_sel_o       (wd_sel),
        .alu_src_b_o    (alu_src_b),
        .alu_op_o       (alu_op),
        .illegal_o      (illegal),
        .bus_err_o      (bus_err),
        .state_o        (state)
    );

    // Control word layout:
    // {pc_write, pc_src, ir_write, mem_read, mem_write, reg_write,
    //  wd_sel, alu_src_b, alu_op, illegal, bus_err, state}
    function automatic logic [16:0] pk(
        input logic pcw, input logic [1:0] pcs, input logic irw,
        input logic mr, input logic mw, input logic rw, input logic [1:0] wds,
        input logic asb, input logic [1:0] aop, input logic ill,
        input logic berr, input logic [2:0] st);
        pk = {pcw, pcs, irw, mr, mw, rw, wds, asb, aop, ill, berr, st};
    endfunction

    // Frequently used expected words
    localparam logic [16:0] W_FETCH_OK   = 17'({1'b1, 2'b00, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0, 3'd0});
    localparam logic [16:0] W_FETCH_WAIT = 17'({1'b0, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0, 3'd0});
    localparam logic [16:0] W_DECODE     = 17'({1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0, 3'd1});

    task automatic check(input string tag, input logic [16:0] got, input logic [16:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %05h expected %05h", tag, got, exp);
        end
    endtask

    // Inputs are already applied; sample mid-cycle, then advance one clock.
    task automatic cyc(input string tag, input logic [16:0] exp);
        #4;
        check(tag, {pc_write, pc_src, ir_write, mem_read, mem_write, reg_write,
                    wd_sel, alu_src_b, alu_op, illegal, bus_err, state}, exp);
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; instr_op = '0; mem_ready = 1'b1; branch_taken = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        // Reset held: strobes forced low even with mem_ready=1 in FETCH
        cyc("reset", pk(0,2'b00,0,0,0,0,2'b00,0,2'b00,0,0,3'd0));
        rst = 1'b0;

        // 1) R-type
        instr_op = OP_R;
        cyc("r_fetch",  W_FETCH_OK);
        cyc("r_decode", W_DECODE);
        cyc("r_exec",   pk(0,2'b00,0,0,0,0,2'b00,0,2'b10,0,0,3'd2));
        cyc("r_wb",     pk(0,2'b00,0,0,0,1,2'b00,0,2'b00,0,0,3'd4));

        // I-ALU and LUI EXEC selects
        instr_op = OP_I;
        cyc("i_fetch",  W_FETCH_OK);
        cyc("i_decode", W_DECODE);
        cyc("i_exec",   pk(0,2'b00,0,0,0,0,2'b00,1,2'b10,0,0,3'd2));
        cyc("i_wb",     pk(0,2'b00,0,0,0,1,2'b00,0,2'b00,0,0,3'd4));
        instr_op = OP_LUI;
        cyc("lui_fetch",  W_FETCH_OK);
        cyc("lui_decode", W_DECODE);
        cyc("lui_exec",   pk(0,2'b00,0,0,0,0,2'b00,1,2'b11,0,0,3'd2));
        cyc("lui_wb",     pk(0,2'b00,0,0,0,1,2'b00,0,2'b00,0,0,3'd4));

        // 2) LW with three wait cycles in MEM
        instr_op = OP_LW;
        cyc("lw_fetch",  W_FETCH_OK);
        cyc("lw_decode", W_DECODE);
        cyc("lw_exec",   pk(0,2'b00,0,0,0,0,2'b00,1,2'b00,0,0,3'd2));
        mem_ready = 1'b0;
        for (int i = 0; i < 3; i++)
            cyc("lw_mem_wait", pk(0,2'b00,0,1,0,0,2'b00,0,2'b00,0,0,3'd3));
        mem_ready = 1'b1;
        cyc("lw_mem_done", pk(0,2'b00,0,1,0,0,2'b00,0,2'b00,0,0,3'd3));
        cyc("lw_wb",       pk(0,2'b00,0,0,0,1,2'b01,0,2'b00,0,0,3'd4));

        // 3) Branch taken / not taken
        instr_op = OP_BR; branch_taken = 1'b1;
        cyc("br_t_fetch",  W_FETCH_OK);
        cyc("br_t_decode", W_DECODE);
        cyc("br_t_exec",   pk(1,2'b01,0,0,0,0,2'b00,0,2'b01,0,0,3'd2));
        branch_taken = 1'b0;
        cyc("br_n_fetch",  W_FETCH_OK);
        cyc("br_n_decode", W_DECODE);
        cyc("br_n_exec",   pk(0,2'b01,0,0,0,0,2'b00,0,2'b01,0,0,3'd2));

        // 4) JAL / JALR
        instr_op = OP_JAL;
        cyc("jal_fetch",  W_FETCH_OK);
        cyc("jal_decode", W_DECODE);
        cyc("jal_exec",   pk(0,2'b00,0,0,0,0,2'b00,1,2'b00,0,0,3'd2));
        cyc("jal_wb",     pk(1,2'b01,0,0,0,1,2'b10,0,2'b00,0,0,3'd4));
        instr_op = OP_JALR;
        cyc("jalr_fetch",  W_FETCH_OK);
        cyc("jalr_decode", W_DECODE);
        cyc("jalr_exec",   pk(0,2'b00,0,0,0,0,2'b00,1,2'b00,0,0,3'd2));
        cyc("jalr_wb",     pk(1,2'b10,0,0,0,1,2'b10,0,2'b00,0,0,3'd4));

        // 5) Illegal opcode, then FETCH timeout twice (counter restarts at 0)
        instr_op = 7'h7F;
        cyc("ill_fetch",  W_FETCH_OK);
        cyc("ill_decode", pk(0,2'b00,0,0,0,0,2'b00,0,2'b00,1,0,3'd1));
        mem_ready = 1'b0;
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < 3; i++)
                cyc("to_wait", W_FETCH_WAIT);
            cyc("to_buserr", pk(0,2'b00,0,1,0,0,2'b00,0,2'b00,0,1,3'd0));
        end

        // SW, zero-wait completion back to FETCH
        mem_ready = 1'b1; instr_op = OP_SW;
        cyc("sw_fetch",  W_FETCH_OK);
        cyc("sw_decode", W_DECODE);
        cyc("sw_exec",   pk(0,2'b00,0,0,0,0,2'b00,1,2'b00,0,0,3'd2));
        cyc("sw_mem",    pk(0,2'b00,0,0,1,0,2'b00,0,2'b00,0,0,3'd3));

        // 6) SW interrupted by reset in MEM
        cyc("swr_fetch",  W_FETCH_OK);
        cyc("swr_decode", W_DECODE);
        cyc("swr_exec",   pk(0,2'b00,0,0,0,0,2'b00,1,2'b00,0,0,3'd2));
        mem_ready = 1'b0;
        cyc("swr_mem_wait", pk(0,2'b00,0,0,1,0,2'b00,0,2'b00,0,0,3'd3));
        rst = 1'b1; mem_ready = 1'b1;
        cyc("swr_mem_rst", pk(0,2'b00,0,0,0,0,2'b00,0,2'b00,0,0,3'd3));
        rst = 1'b0; mem_ready = 1'b0;
        cyc("swr_after_rst", W_FETCH_WAIT);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
